sram_read_master: RTL and testbench

Synchronous SRAM read-cycle initiator for the SRAM sampling board, running on the 200 MHz sampling clock. It drives active-low chip enable, active-low output enable and a 15-bit address onto the SRAM bus, and captures the 8-bit data returned. It generates read bursts with programmable setup, access and hold phases. The bench and bring-up logic use it to drive the SRAM bus that the sampler front end snoops.

---
 rtl/sram_read_master.sv | 127 ++++++++++++
 tb/tb_sram_read_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sram_read_master.sv
// sram_read_master: SRAM read-burst initiator with programmable setup, access and hold phases
module sram_read_master #(
  parameter int T_SETUP = 2,
  parameter int T_ACC   = 4,
  parameter int T_HOLD  = 2
) (
  input  logic        clk_200,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] start_addr,
  input  logic [15:0] burst_len,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic [14:0] sram_addr,
  input  logic [7:0]  sram_data,
  output logic        rd_valid,
  output logic [14:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  localparam logic [3:0] P_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] P_ACC   = 4'(T_ACC - 1);
  localparam logic [3:0] P_HOLD  = 4'(T_HOLD - 1);
  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] words_q, words_d;
  logic [14:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d, done_q, done_d;
  always_ff @(posedge clk_200) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  // Each phase loads its length minus one and advances when the counter reaches zero.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    words_d    = words_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && burst_len == 16'd0) done_d = 1'b1;
        else if (start) begin
          addr_d  = start_addr;
          words_d = burst_len;
          ce_n_d  = 1'b0;
          busy_d  = 1'b1;
          phase_d = P_SETUP;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_q == 4'd0) begin
          oe_n_d  = 1'b0;
          phase_d = P_ACC;
          state_d = ACCESS;
        end else phase_d = phase_q - 4'd1;
      end
      ACCESS: begin
        if (phase_q == 4'd0) begin
          rd_data_d  = sram_data;
          rd_addr_d  = addr_q;
          rd_valid_d = 1'b1;
          ce_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          phase_d    = P_HOLD;
          state_d    = HOLD;
        end else phase_d = phase_q - 4'd1;
      end
      HOLD: begin
        if (phase_q == 4'd0 && words_q > 16'd1) begin
          words_d = words_q - 16'd1;
          addr_d  = addr_q + 15'd1;
          ce_n_d  = 1'b0;
          phase_d = P_SETUP;
          state_d = SETUP;
        end else if (phase_q == 4'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else phase_d = phase_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_addr = addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_sram_read_master.sv
// tb_sram_read_master: checks two instances (default and 1/1/1 timing) against a timeline model
module tb_sram_read_master;
  logic clk_200 = 1'b0;
  always #5 clk_200 = ~clk_200;
  logic        reset = 1'b1, start = 1'b0;
  logic [14:0] start_addr = '0;
  logic [15:0] burst_len = '0;
  logic [1:0]  ce_n, oe_n, rd_valid, busy, done;
  logic [14:0] addr[2], rd_addr[2];
  logic [7:0]  data[2], rd_data[2];
  assign data[0] = oe_n[0] ? 8'h00 : (addr[0][7:0] ^ 8'hA5);
  assign data[1] = oe_n[1] ? 8'h00 : (addr[1][7:0] ^ 8'hA5);
  sram_read_master dut_a (
    .clk_200(clk_200), .reset(reset), .start(start), .start_addr(start_addr), .burst_len(burst_len),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_addr(addr[0]), .sram_data(data[0]),
    .rd_valid(rd_valid[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .busy(busy[0]), .done(done[0]));
  sram_read_master #(.T_SETUP(1), .T_ACC(1), .T_HOLD(1)) dut_b (
    .clk_200(clk_200), .reset(reset), .start(start), .start_addr(start_addr), .burst_len(burst_len),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_addr(addr[1]), .sram_data(data[1]),
    .rd_valid(rd_valid[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .busy(busy[1]), .done(done[1]));
  // Reference model: a burst is just (start edge, length, base address); outputs follow from edge arithmetic.
  int ts[2] = '{2, 1};
  int ta[2] = '{4, 1};
  int th[2] = '{2, 1};
  int e = 0;
  int e0[2], n[2];
  logic [14:0] a0[2], last_a[2], lrd_a[2];
  logic [7:0]  lrd_d[2];
  bit act[2], dn[2];
  int vectors = 0, miscompares = 0;
  int rv_cnt[2], done_cnt[2];
  task automatic model_update();
    e++;
    for (int i = 0; i < 2; i++) begin
      int p = ts[i] + ta[i] + th[i];
      dn[i] = 1'b0;
      if (reset) begin
        act[i] = 1'b0;
        last_a[i] = '0;
        lrd_a[i] = '0;
        lrd_d[i] = '0;
      end else begin
        if (act[i] && e - e0[i] == n[i] * p) begin
          act[i] = 1'b0;
          dn[i] = 1'b1;
          last_a[i] = a0[i] + 15'(n[i] - 1);
        end else if (!act[i] && start) begin
          if (burst_len == 16'd0) dn[i] = 1'b1;
          else begin
            act[i] = 1'b1;
            e0[i] = e;
            n[i] = int'(burst_len);
            a0[i] = start_addr;
          end
        end
        if (act[i] && (e - e0[i]) % p == ts[i] + ta[i]) begin
          lrd_a[i] = a0[i] + 15'((e - e0[i]) / p);
          lrd_d[i] = lrd_a[i][7:0] ^ 8'hA5;
        end
      end
    end
  endtask
  function automatic logic [42:0] expv(int i);
    int p = ts[i] + ta[i] + th[i];
    int d = e - e0[i];
    logic c = 1'b1, oe = 1'b1, rv = 1'b0, b = 1'b0;
    logic [14:0] ad = last_a[i];
    if (act[i]) begin
      c  = !(d % p < ts[i] + ta[i]);
      oe = !(d % p >= ts[i] && d % p < ts[i] + ta[i]);
      rv = (d % p == ts[i] + ta[i]);
      ad = a0[i] + 15'(d / p);
      b  = 1'b1;
    end
    return {c, oe, ad, b, dn[i], rv, lrd_a[i], lrd_d[i]};
  endfunction
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic [42:0] got = {ce_n[i], oe_n[i], addr[i], busy[i], done[i], rd_valid[i], rd_addr[i], rd_data[i]};
      logic [42:0] ex = expv(i);
      vectors++;
      if (got !== ex) begin
        miscompares++;
        $display("FAIL outputs dut%0d edge %0d: {ce_n,oe_n,addr,busy,done,rd_valid,rd_addr,rd_data} got %h expected %h", i, e, got, ex);
      end
      vectors++;
      if (!oe_n[i] && ce_n[i]) begin
        miscompares++;
        $display("FAIL protocol dut%0d edge %0d: oe_n=%b while ce_n=%b", i, e, oe_n[i], ce_n[i]);
      end
      rv_cnt[i] += int'(rd_valid[i]);
      done_cnt[i] += int'(done[i]);
    end
  endtask
  task automatic step();
    @(posedge clk_200);
    model_update();
    @(negedge clk_200);
    compare();
  endtask
  task automatic chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  task automatic pulse_start(logic [14:0] a, logic [15:0] l);
    start_addr = a;
    burst_len = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(output int c);
    for (c = 0; c < 1000; c++) begin
      if (done[0]) break;
      step();
    end
    if (c == 1000) chk("done timeout", c, -1);
  endtask
  typedef struct {
    logic [14:0] addr;
    logic [15:0] len;
    int          cycles;
    logic [14:0] last;
    logic [7:0]  dat;
  } vec_t;
  vec_t tbl[5];
  initial begin
    int c;
    tbl[0] = '{15'h0123, 16'd1, 8,  15'h0123, 8'h86};
    tbl[1] = '{15'h7FFE, 16'd4, 32, 15'h0001, 8'hA4};
    tbl[2] = '{15'h0040, 16'd0, 0,  15'h0000, 8'h00};
    tbl[3] = '{15'h7FFF, 16'd2, 16, 15'h0000, 8'hA5};
    tbl[4] = '{15'h1234, 16'd3, 24, 15'h1236, 8'h93};
    step();
    step();
    reset = 1'b0;
    step();
    for (int t = 0; t < 5; t++) begin
      pulse_start(tbl[t].addr, tbl[t].len);
      wait_done(c);
      chk($sformatf("table%0d done latency", t), c, tbl[t].cycles);
      if (tbl[t].len != 16'd0) begin
        chk($sformatf("table%0d last rd_addr", t), int'(rd_addr[0]), int'(tbl[t].last));
        chk($sformatf("table%0d last rd_data", t), int'(rd_data[0]), int'(tbl[t].dat));
      end
      step();
      step();
    end
    rv_cnt = '{0, 0};
    done_cnt = '{0, 0};
    start_addr = 15'h0100;
    burst_len = 16'd3;
    start = 1'b1;
    repeat (25) step();
    chk("held start rd_valid count", rv_cnt[0], 3);
    chk("held start done count", done_cnt[0], 1);
    step();
    chk("held start restarts after done", int'(busy[0]), 1);
    start = 1'b0;
    wait_done(c);
    repeat (3) step();
    pulse_start(15'h0200, 16'd5);
    repeat (18) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset mid-burst busy", int'(busy[0]), 0);
    rv_cnt = '{0, 0};
    done_cnt = '{0, 0};
    repeat (30) step();
    chk("after abort rd_valid count", rv_cnt[0], 0);
    chk("after abort done count", done_cnt[0], 0);
    repeat (1500) begin
      start = ($urandom % 4) == 0;
      start_addr = 15'($urandom);
      burst_len = 16'($urandom_range(0, 5));
      reset = ($urandom % 80) == 0;
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (50) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
